// File: rtl/phaser_out_ctrl_if.sv
// Control/status bundle between a phaser-out controller and its user.
// Signal names keep the phaser primitive's pin names.
interface phaser_out_ctrl_if;
  logic       DIVIDERST;
  logic       FINEENABLE;
  logic       FINEINC;
  logic       COUNTERLOADEN;
  logic [5:0] COUNTERLOADVAL;
  logic       COUNTERREADEN;
  logic       BURSTPENDING;
  logic       OCLKDIV;
  logic       OCLKDIV_EN;
  logic [5:0] FINETAP;
  logic       FINEOVERFLOW;
  logic [5:0] COUNTERREADVAL;
  logic       OSERDESRST;
  logic       WRENABLE;

  // User side: drives requests, observes status
  modport master (
    output DIVIDERST, FINEENABLE, FINEINC, COUNTERLOADEN, COUNTERLOADVAL,
           COUNTERREADEN, BURSTPENDING,
    input  OCLKDIV, OCLKDIV_EN, FINETAP, FINEOVERFLOW, COUNTERREADVAL,
           OSERDESRST, WRENABLE
  );

  // Controller side
  modport slave (
    input  DIVIDERST, FINEENABLE, FINEINC, COUNTERLOADEN, COUNTERLOADVAL,
           COUNTERREADEN, BURSTPENDING,
    output OCLKDIV, OCLKDIV_EN, FINETAP, FINEOVERFLOW, COUNTERREADVAL,
           OSERDESRST, WRENABLE
  );
endinterface

// File: rtl/phaser_out_ctrl.sv
// Phaser-out controller: SYSCLK divider, serializer-reset sequencing,
// burst write enable, saturating fine-tap stepper and coarse register.
module phaser_out_ctrl #(
  parameter int    CLKOUT_DIV         = 4,
  parameter int    FINE_DELAY         = 0,
  parameter string EN_OSERDES_RST     = "FALSE",
  parameter int    OSERDES_RST_CYCLES = 8
) (
  input  logic             SYSCLK,
  input  logic             RST_N,
  phaser_out_ctrl_if.slave bus
);

  // Reject illegal parameterisations at elaboration
  if (CLKOUT_DIV < 2 || CLKOUT_DIV > 16) begin : g_bad_div
    $fatal(1, "phaser_out_ctrl: CLKOUT_DIV=%0d outside 2..16", CLKOUT_DIV);
  end
  if (FINE_DELAY < 0 || FINE_DELAY > 63) begin : g_bad_fine
    $fatal(1, "phaser_out_ctrl: FINE_DELAY=%0d outside 0..63", FINE_DELAY);
  end
  if (EN_OSERDES_RST != "TRUE" && EN_OSERDES_RST != "FALSE") begin : g_bad_en
    $fatal(1, "phaser_out_ctrl: EN_OSERDES_RST must be TRUE or FALSE");
  end
  if (OSERDES_RST_CYCLES < 1 || OSERDES_RST_CYCLES > 15) begin : g_bad_cyc
    $fatal(1, "phaser_out_ctrl: OSERDES_RST_CYCLES=%0d outside 1..15", OSERDES_RST_CYCLES);
  end

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TAP_W = 6;
  localparam logic [CNT_W-1:0] LP_DIV_LAST  = CNT_W'(CLKOUT_DIV - 1);
  localparam logic [CNT_W-1:0] LP_DIV_HALF  = CNT_W'(CLKOUT_DIV / 2);
  localparam logic [CNT_W-1:0] LP_HOLD_LAST = CNT_W'(OSERDES_RST_CYCLES - 1);
  localparam logic [TAP_W-1:0] LP_FINE_RST  = TAP_W'(FINE_DELAY);
  localparam logic [TAP_W-1:0] LP_TAP_MAX   = '1;
  localparam logic             LP_HOLD_EN   = (EN_OSERDES_RST == "TRUE");

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_div_cnt, w_div_nxt, w_div_inc;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_nxt;
  logic             w_boundary;
  logic             r_oclkdiv, w_oclkdiv_nxt;
  logic             r_oclkdiv_en, w_oclkdiv_en_nxt;
  logic             r_wrenable, w_wrenable_nxt;
  logic             r_oserdesrst, w_oserdesrst_nxt;
  logic [TAP_W-1:0] r_finetap, w_finetap_nxt;
  logic             r_fineovf, w_fineovf_nxt;
  logic [TAP_W-1:0] r_coarse;
  logic [TAP_W-1:0] r_readval;

  // Divider advance, sequencing FSM next state and registered-output next values
  always_comb begin
    w_div_inc        = (r_div_cnt == LP_DIV_LAST) ? '0 : r_div_cnt + CNT_W'(1);
    w_boundary       = (w_div_inc == '0);
    w_div_nxt        = w_div_inc;
    w_oclkdiv_nxt    = (w_div_inc < LP_DIV_HALF);
    w_oclkdiv_en_nxt = w_boundary;
    w_state_nxt      = r_state;
    w_hold_nxt       = r_hold_cnt;
    w_wrenable_nxt   = r_wrenable;

    case (r_state)
      S_WAIT: begin
        w_wrenable_nxt = 1'b0;
        if (w_boundary) begin
          w_hold_nxt  = '0;
          w_state_nxt = LP_HOLD_EN ? S_HOLD : S_RUN;
        end
      end
      S_HOLD: begin
        w_wrenable_nxt = 1'b0;
        if (w_boundary) begin
          if (r_hold_cnt == LP_HOLD_LAST) begin
            w_hold_nxt  = '0;
            w_state_nxt = S_RUN;
          end else begin
            w_hold_nxt = r_hold_cnt + CNT_W'(1);
          end
        end
      end
      S_RUN: begin
        if (w_boundary) begin
          w_wrenable_nxt = bus.BURSTPENDING;
        end
      end
      default: begin
        w_wrenable_nxt = 1'b0;
        w_hold_nxt     = '0;
        w_state_nxt    = S_WAIT;
      end
    endcase

    // Divider restart wins over everything on the divided-clock side
    if (bus.DIVIDERST) begin
      w_div_nxt        = '0;
      w_oclkdiv_nxt    = 1'b0;
      w_oclkdiv_en_nxt = 1'b0;
      w_wrenable_nxt   = 1'b0;
      w_hold_nxt       = '0;
      w_state_nxt      = S_WAIT;
    end

    w_oserdesrst_nxt = (w_state_nxt != S_RUN);
  end

  // FSM state register
  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Divider, hold counter and divided-clock-domain outputs
  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_div_cnt    <= '0;
      r_hold_cnt   <= '0;
      r_oclkdiv    <= 1'b0;
      r_oclkdiv_en <= 1'b0;
      r_wrenable   <= 1'b0;
      r_oserdesrst <= 1'b1;
    end else begin
      r_div_cnt    <= w_div_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_oclkdiv    <= w_oclkdiv_nxt;
      r_oclkdiv_en <= w_oclkdiv_en_nxt;
      r_wrenable   <= w_wrenable_nxt;
      r_oserdesrst <= w_oserdesrst_nxt;
    end
  end

  // Saturating fine-tap step: one step per enabled cycle, overflow flags a clipped step
  always_comb begin
    w_finetap_nxt = r_finetap;
    w_fineovf_nxt = r_fineovf;
    if (bus.FINEENABLE) begin
      if (bus.FINEINC) begin
        if (r_finetap == LP_TAP_MAX) begin
          w_fineovf_nxt = 1'b1;
        end else begin
          w_finetap_nxt = r_finetap + TAP_W'(1);
          w_fineovf_nxt = 1'b0;
        end
      end else begin
        if (r_finetap == '0) begin
          w_fineovf_nxt = 1'b1;
        end else begin
          w_finetap_nxt = r_finetap - TAP_W'(1);
          w_fineovf_nxt = 1'b0;
        end
      end
    end
  end

  // Fine-tap registers
  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_finetap <= LP_FINE_RST;
      r_fineovf <= 1'b0;
    end else begin
      r_finetap <= w_finetap_nxt;
      r_fineovf <= w_fineovf_nxt;
    end
  end

  // Coarse register; a same-cycle read captures the value before the load
  always_ff @(posedge SYSCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_coarse  <= '0;
      r_readval <= '0;
    end else begin
      if (bus.COUNTERREADEN) begin
        r_readval <= r_coarse;
      end
      if (bus.COUNTERLOADEN) begin
        r_coarse <= bus.COUNTERLOADVAL;
      end
    end
  end

  assign bus.OCLKDIV        = r_oclkdiv;
  assign bus.OCLKDIV_EN     = r_oclkdiv_en;
  assign bus.FINETAP        = r_finetap;
  assign bus.FINEOVERFLOW   = r_fineovf;
  assign bus.COUNTERREADVAL = r_readval;
  assign bus.OSERDESRST     = r_oserdesrst;
  assign bus.WRENABLE       = r_wrenable;

endmodule

// File: tb/tb_phaser_out_ctrl.sv
// Bench for phaser_out_ctrl: two instances (hold phase on / off) driven by the
// same directed stimulus, checked every cycle against a cycle-count model and
// at key points against hand-computed literals.
module tb_phaser_out_ctrl;

  logic       SYSCLK;
  logic       RST_N;
  logic       divrst, fe, fi, le, re, bp;
  logic [5:0] lv;

  int n_checks = 0;
  int n_fail   = 0;

  phaser_out_ctrl_if bus_a ();
  phaser_out_ctrl_if bus_b ();

  assign bus_a.DIVIDERST      = divrst;
  assign bus_a.FINEENABLE     = fe;
  assign bus_a.FINEINC        = fi;
  assign bus_a.COUNTERLOADEN  = le;
  assign bus_a.COUNTERLOADVAL = lv;
  assign bus_a.COUNTERREADEN  = re;
  assign bus_a.BURSTPENDING   = bp;
  assign bus_b.DIVIDERST      = divrst;
  assign bus_b.FINEENABLE     = fe;
  assign bus_b.FINEINC        = fi;
  assign bus_b.COUNTERLOADEN  = le;
  assign bus_b.COUNTERLOADVAL = lv;
  assign bus_b.COUNTERREADEN  = re;
  assign bus_b.BURSTPENDING   = bp;

  phaser_out_ctrl #(
    .CLKOUT_DIV(4), .FINE_DELAY(62), .EN_OSERDES_RST("TRUE"), .OSERDES_RST_CYCLES(2)
  ) dut_a (
    .SYSCLK(SYSCLK), .RST_N(RST_N), .bus(bus_a)
  );

  phaser_out_ctrl #(
    .CLKOUT_DIV(5), .FINE_DELAY(0), .EN_OSERDES_RST("FALSE"), .OSERDES_RST_CYCLES(8)
  ) dut_b (
    .SYSCLK(SYSCLK), .RST_N(RST_N), .bus(bus_b)
  );

  initial begin
    SYSCLK = 1'b0;
    forever #5 SYSCLK = ~SYSCLK;
  end

  // Model: k = edges since restart, b = divided boundaries since restart,
  // run_b = boundary index at which writes become possible.
  typedef struct {
    int div; int fine_rst; int run_b;
    int k; int b;
    bit oclk; bit en; bit wren; bit osr;
    int tap; bit ovf; int coarse; int rdv;
  } model_t;

  model_t m[2];

  function automatic model_t mreset(model_t x);
    model_t y = x;
    y.k = 0; y.b = 0; y.oclk = 0; y.en = 0; y.wren = 0; y.osr = 1;
    y.tap = x.fine_rst; y.ovf = 0; y.coarse = 0; y.rdv = 0;
    return y;
  endfunction

  function automatic model_t mstep(model_t x, bit dr, bit fen, bit finc,
                                   bit lden, int ldv, bit rden, bit bpend);
    model_t y = x;
    if (dr) begin
      y.k = 0; y.b = 0; y.oclk = 0; y.en = 0; y.wren = 0; y.osr = 1;
    end else begin
      y.k    = x.k + 1;
      y.oclk = (y.k % y.div) < (y.div / 2);
      y.en   = (y.k % y.div) == 0;
      if (y.en) begin
        y.b    = x.b + 1;
        y.wren = (y.b > y.run_b) ? bpend : 1'b0;
      end
      y.osr = (y.b < y.run_b);
    end
    if (fen) begin
      if (finc) begin
        if (x.tap == 63) y.ovf = 1; else begin y.tap = x.tap + 1; y.ovf = 0; end
      end else begin
        if (x.tap == 0) y.ovf = 1; else begin y.tap = x.tap - 1; y.ovf = 0; end
      end
    end
    if (rden) y.rdv = x.coarse;
    if (lden) y.coarse = ldv;
    return y;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  initial begin
    bit s_dr, s_fe, s_fi, s_le, s_re, s_bp;
    int s_lv;
    m[0].div = 4; m[0].fine_rst = 62; m[0].run_b = 3;
    m[1].div = 5; m[1].fine_rst = 0;  m[1].run_b = 1;
    m[0] = mreset(m[0]);
    m[1] = mreset(m[1]);
    forever begin
      @(posedge SYSCLK or negedge RST_N);
      s_dr = divrst; s_fe = fe; s_fi = fi; s_le = le; s_re = re; s_bp = bp;
      s_lv = int'(lv);
      for (int i = 0; i < 2; i++) begin
        if (!RST_N) m[i] = mreset(m[i]);
        else        m[i] = mstep(m[i], s_dr, s_fe, s_fi, s_le, s_lv, s_re, s_bp);
      end
      #1;
      chk("a_oclkdiv",    int'(bus_a.OCLKDIV),        int'(m[0].oclk));
      chk("a_oclkdiv_en", int'(bus_a.OCLKDIV_EN),     int'(m[0].en));
      chk("a_wrenable",   int'(bus_a.WRENABLE),       int'(m[0].wren));
      chk("a_oserdesrst", int'(bus_a.OSERDESRST),     int'(m[0].osr));
      chk("a_finetap",    int'(bus_a.FINETAP),        m[0].tap);
      chk("a_fineovf",    int'(bus_a.FINEOVERFLOW),   int'(m[0].ovf));
      chk("a_readval",    int'(bus_a.COUNTERREADVAL), m[0].rdv);
      chk("b_oclkdiv",    int'(bus_b.OCLKDIV),        int'(m[1].oclk));
      chk("b_oclkdiv_en", int'(bus_b.OCLKDIV_EN),     int'(m[1].en));
      chk("b_wrenable",   int'(bus_b.WRENABLE),       int'(m[1].wren));
      chk("b_oserdesrst", int'(bus_b.OSERDESRST),     int'(m[1].osr));
      chk("b_finetap",    int'(bus_b.FINETAP),        m[1].tap);
      chk("b_fineovf",    int'(bus_b.FINEOVERFLOW),   int'(m[1].ovf));
      chk("b_readval",    int'(bus_b.COUNTERREADVAL), m[1].rdv);
    end
  end

  // Hand-computed expectations for edges 1..12 after reset release
  int exp_oclk_a[12] = '{1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1};
  int exp_en_a[12]   = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
  int exp_osr_a[12]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int exp_en_b[12]   = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
  int exp_tap_a[4]   = '{63, 63, 63, 62};
  int exp_ovf_a[4]   = '{0, 1, 1, 0};
  int exp_tap_b[4]   = '{1, 2, 3, 2};

  task automatic tick();
    @(posedge SYSCLK);
    #2;
  endtask

  task automatic idle_inputs();
    divrst = 0; fe = 0; fi = 0; le = 0; re = 0; bp = 0; lv = '0;
  endtask

  // Directed stimulus with literal spot checks
  initial begin
    idle_inputs();
    RST_N = 1'b1;
    #3 RST_N = 1'b0;
    #1;
    chk("lit_reset_tap_a", int'(bus_a.FINETAP), 62);
    chk("lit_reset_osr_a", int'(bus_a.OSERDESRST), 1);
    chk("lit_reset_wren_a", int'(bus_a.WRENABLE), 0);
    tick();
    tick();
    RST_N = 1'b1;

    // Edges 1..12: divider pattern, fine saturation, coarse load/read, hold
    for (int e = 1; e <= 12; e++) begin
      fe = (e <= 4);
      fi = (e <= 3);
      le = (e == 5) || (e == 6);
      lv = (e == 5) ? 6'd5 : 6'd40;
      re = (e == 6) || (e == 7);
      bp = (e >= 8);
      tick();
      chk("lit_oclkdiv_a", int'(bus_a.OCLKDIV), exp_oclk_a[e-1]);
      chk("lit_en_a", int'(bus_a.OCLKDIV_EN), exp_en_a[e-1]);
      chk("lit_osr_a", int'(bus_a.OSERDESRST), exp_osr_a[e-1]);
      chk("lit_en_b", int'(bus_b.OCLKDIV_EN), exp_en_b[e-1]);
      chk("lit_wren_a_hold", int'(bus_a.WRENABLE), 0);
      if (e <= 4) begin
        chk("lit_tap_a", int'(bus_a.FINETAP), exp_tap_a[e-1]);
        chk("lit_ovf_a", int'(bus_a.FINEOVERFLOW), exp_ovf_a[e-1]);
        chk("lit_tap_b", int'(bus_b.FINETAP), exp_tap_b[e-1]);
      end
      if (e == 6) chk("lit_read_preload", int'(bus_a.COUNTERREADVAL), 5);
      if (e == 7) chk("lit_read_postload", int'(bus_a.COUNTERREADVAL), 40);
    end
    fe = 0; le = 0; re = 0;

    // Edges 13..18: write enable rises at the first boundary inside RUN
    for (int e = 13; e <= 18; e++) begin
      tick();
      if (e == 15) chk("lit_wren_a_e15", int'(bus_a.WRENABLE), 0);
      if (e == 16) chk("lit_wren_a_e16", int'(bus_a.WRENABLE), 1);
    end

    // Edge 19: mid-period divider restart
    divrst = 1;
    tick();
    divrst = 0;
    chk("lit_divrst_wren_a", int'(bus_a.WRENABLE), 0);
    chk("lit_divrst_osr_a", int'(bus_a.OSERDESRST), 1);
    chk("lit_divrst_en_a", int'(bus_a.OCLKDIV_EN), 0);
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk("lit_en_after_divrst", int'(bus_a.OCLKDIV_EN), (e == 4) ? 1 : 0);
    end

    // Mixed pattern exercising everything at once
    for (int i = 0; i < 40; i++) begin
      fe     = (i % 3) != 0;
      fi     = (i % 10) < 6;
      le     = (i % 7) == 0;
      lv     = 6'(i * 9);
      re     = (i % 4) == 1;
      bp     = (i % 5) != 4;
      divrst = (i == 25);
      tick();
    end
    idle_inputs();

    // Restart, run into A's HOLD phase and B's active burst, then reset
    divrst = 1;
    tick();
    divrst = 0;
    bp = 1;
    for (int e = 1; e <= 11; e++) tick();
    chk("lit_pre_rst_osr_a", int'(bus_a.OSERDESRST), 1);
    chk("lit_pre_rst_wren_b", int'(bus_b.WRENABLE), 1);
    RST_N = 1'b0;
    #2;
    chk("lit_rst_osr_a", int'(bus_a.OSERDESRST), 1);
    chk("lit_rst_tap_a", int'(bus_a.FINETAP), 62);
    chk("lit_rst_wren_b", int'(bus_b.WRENABLE), 0);
    chk("lit_rst_osr_b", int'(bus_b.OSERDESRST), 1);
    chk("lit_rst_rdv_a", int'(bus_a.COUNTERREADVAL), 0);
    tick();
    RST_N = 1'b1;

    // Full hold sequence after reset, with a burst pending throughout
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 11) chk("lit_osr_a_e11", int'(bus_a.OSERDESRST), 1);
      if (e == 12) chk("lit_osr_a_e12", int'(bus_a.OSERDESRST), 0);
      if (e == 16) chk("lit_wren_a_run", int'(bus_a.WRENABLE), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
